// File: rtl/mole_field_render.sv
// mole_field_render
//
// Pixel source for the whack-a-mole playfield. Takes the LCD driver's request
// coordinates and returns the matching RGB888 colour one clock later. The
// playfield is a 3x3 grid of holes. Each hole has a mole whose height is
// animated by its own small state machine, advanced once per frame on the
// last active pixel.
//
// Ports:
//   clk           pixel clock (same as the LCD driver)
//   rst           asynchronous active-high reset
//   pixel_xpos    requested column, 0-based
//   pixel_ypos    requested line, 1-based (0 = no request)
//   h_disp        active width from the driver
//   v_disp        active height from the driver
//   mole_up[8:0]  per-hole "mole should be out" level (index = row*3+col)
//   hit[8:0]      per-hole single-cycle whack pulses
//   pixel_data    registered RGB888 colour, 1 clk after the request
//   hit_ack[8:0]  one-cycle pulse per accepted hit
//   mole_visible  registered per-hole (height != 0)
module mole_field_render #(
    parameter int          GRID_X0    = 48,
    parameter int          GRID_Y0    = 24,
    parameter int          PITCH_X    = 128,
    parameter int          PITCH_Y    = 80,
    parameter int          HOLE_W     = 96,
    parameter int          HOLE_H     = 64,
    parameter int          STEP       = 4,
    parameter logic [23:0] BG_COLOR   = 24'h2E8B57,
    parameter logic [23:0] HOLE_COLOR = 24'h3B2A1A,
    parameter logic [23:0] MOLE_COLOR = 24'h8B5A2B,
    parameter logic [23:0] HIT_COLOR  = 24'hFF2020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] pixel_xpos,
    input  logic [10:0] pixel_ypos,
    input  logic [10:0] h_disp,
    input  logic [10:0] v_disp,
    input  logic [8:0]  mole_up,
    input  logic [8:0]  hit,
    output logic [23:0] pixel_data,
    output logic [8:0]  hit_ack,
    output logic [8:0]  mole_visible
);

    typedef enum logic [1:0] {
        S_HIDDEN,
        S_RISING,
        S_UP,
        S_SINKING
    } mole_state_t;

    localparam logic [6:0]  STEP7    = 7'(STEP);
    localparam logic [6:0]  HOLE_H7  = 7'(HOLE_H);
    localparam logic [10:0] HOLE_H11 = 11'(HOLE_H);

    // ------------------------------------------------------------------
    // Request decode and frame tick
    // ------------------------------------------------------------------
    logic        req_valid;
    logic [10:0] px;
    logic [10:0] py;
    logic        tick;

    assign req_valid = (pixel_ypos != 11'd0);
    assign px        = pixel_xpos;
    assign py        = pixel_ypos - 11'd1;
    // Last active pixel of the frame: updates land in vertical blanking.
    assign tick      = req_valid && (pixel_ypos == v_disp) &&
                       (pixel_xpos == h_disp - 11'd1);

    // ------------------------------------------------------------------
    // Hole lookup by range comparators (no division)
    // ------------------------------------------------------------------
    logic [2:0]  col_in;
    logic [2:0]  row_in;
    logic [10:0] ly_row [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_axis
            localparam logic [10:0] CX0 = 11'(GRID_X0 + gi * PITCH_X);
            localparam logic [10:0] CX1 = 11'(GRID_X0 + gi * PITCH_X + HOLE_W);
            localparam logic [10:0] RY0 = 11'(GRID_Y0 + gi * PITCH_Y);
            localparam logic [10:0] RY1 = 11'(GRID_Y0 + gi * PITCH_Y + HOLE_H);

            assign col_in[gi] = (px >= CX0) && (px < CX1);
            assign row_in[gi] = (py >= RY0) && (py < RY1);
            // Local row only formed once the row range check passes, so it
            // can never wrap.
            assign ly_row[gi] = row_in[gi] ? (py - RY0) : 11'd0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Hit latch: pending hits are consumed (cleared) on every tick. A hit
    // arriving on the tick cycle itself is folded in combinationally.
    // ------------------------------------------------------------------
    logic [8:0] hitpend_reg;
    logic [8:0] hitpend_next;
    logic [8:0] hit_eff;

    assign hit_eff      = hitpend_reg | hit;
    assign hitpend_next = tick ? 9'd0 : hit_eff;

    // ------------------------------------------------------------------
    // Per-hole mole animation
    // ------------------------------------------------------------------
    logic [8:0] in_hole;
    logic [8:0] mole_px;
    logic [8:0] flag_all;
    logic [8:0] ack_all;
    logic [8:0] vis_next;

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_hole
            localparam int R = gi / 3;
            localparam int C = gi % 3;

            mole_state_t state_reg;
            mole_state_t state_next;
            logic [6:0]  height_reg;
            logic [6:0]  height_next;
            logic        flag_reg;
            logic        flag_next;
            logic        ack_next;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg  <= S_HIDDEN;
                    height_reg <= 7'd0;
                    flag_reg   <= 1'b0;
                end else begin
                    state_reg  <= state_next;
                    height_reg <= height_next;
                    flag_reg   <= flag_next;
                end
            end

            always_comb begin
                state_next  = state_reg;
                height_next = height_reg;
                flag_next   = flag_reg;
                ack_next    = 1'b0;
                if (tick) begin
                    case (state_reg)
                        S_HIDDEN: begin
                            flag_next = 1'b0;
                            // The first rising tick already shows one step.
                            if (mole_up[gi]) begin
                                height_next = STEP7;
                                state_next  = (STEP7 >= HOLE_H7) ? S_UP : S_RISING;
                            end
                        end
                        S_RISING, S_UP: begin
                            if (hit_eff[gi]) begin
                                state_next = S_SINKING;
                                flag_next  = 1'b1;
                                ack_next   = 1'b1;
                            end else if (!mole_up[gi]) begin
                                state_next = S_SINKING;
                            end else if (state_reg == S_RISING) begin
                                if (height_reg >= HOLE_H7 - STEP7) begin
                                    height_next = HOLE_H7;
                                    state_next  = S_UP;
                                end else begin
                                    height_next = height_reg + STEP7;
                                end
                            end
                        end
                        S_SINKING: begin
                            // A whacked mole must go fully down before it
                            // may rise again; an unwhacked one may reverse.
                            if (!flag_reg && mole_up[gi]) begin
                                state_next = S_RISING;
                            end else if (height_reg <= STEP7) begin
                                height_next = 7'd0;
                                state_next  = S_HIDDEN;
                                flag_next   = 1'b0;
                            end else begin
                                height_next = height_reg - STEP7;
                            end
                        end
                        default: begin
                            state_next  = S_HIDDEN;
                            height_next = 7'd0;
                            flag_next   = 1'b0;
                        end
                    endcase
                end
            end

            assign in_hole[gi]  = col_in[C] & row_in[R];
            assign mole_px[gi]  = in_hole[gi] &&
                                  (ly_row[R] >= (HOLE_H11 - {4'd0, height_reg}));
            assign flag_all[gi] = flag_reg;
            assign ack_all[gi]  = ack_next;
            assign vis_next[gi] = (height_next != 7'd0);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Colour select
    // ------------------------------------------------------------------
    logic [23:0] pixel_next;

    always_comb begin
        pixel_next = 24'd0;
        if (req_valid) begin
            pixel_next = BG_COLOR;
            // Holes never overlap, so at most one in_hole bit is set.
            for (int i = 0; i < 9; i++) begin
                if (in_hole[i]) begin
                    if (mole_px[i]) begin
                        pixel_next = flag_all[i] ? HIT_COLOR : MOLE_COLOR;
                    end else begin
                        pixel_next = HOLE_COLOR;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_data   <= 24'd0;
            hit_ack      <= 9'd0;
            mole_visible <= 9'd0;
            hitpend_reg  <= 9'd0;
        end else begin
            pixel_data   <= pixel_next;
            hit_ack      <= ack_all;
            mole_visible <= vis_next;
            hitpend_reg  <= hitpend_next;
        end
    end

endmodule

// File: tb/tb_mole_field_render.sv
// Testbench for mole_field_render: directed pixel probes and frame ticks,
// checked every cycle against a behavioural playfield model, plus literal
// colour/ack/visibility expectations at chosen points.
module tb_mole_field_render;

    localparam int H_DISP = 480;
    localparam int V_DISP = 272;

    localparam logic [23:0] BG   = 24'h2E8B57;
    localparam logic [23:0] HOLE = 24'h3B2A1A;
    localparam logic [23:0] MOLE = 24'h8B5A2B;
    localparam logic [23:0] HITC = 24'hFF2020;

    logic        clk;
    logic        rst;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic [10:0] h_disp;
    logic [10:0] v_disp;
    logic [8:0]  mole_up;
    logic [8:0]  hit;
    logic [23:0] pixel_data;
    logic [8:0]  hit_ack;
    logic [8:0]  mole_visible;

    mole_field_render dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_xpos   (pixel_xpos),
        .pixel_ypos   (pixel_ypos),
        .h_disp       (h_disp),
        .v_disp       (v_disp),
        .mole_up      (mole_up),
        .hit          (hit),
        .pixel_data   (pixel_data),
        .hit_ack      (hit_ack),
        .mole_visible (mole_visible)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Height in pixels, direction of travel (+1 up, -1 down, 0 parked),
    // whacked flag, and pending hits for the coming frame tick.
    int         m_h    [9];
    int         m_dir  [9];
    bit         m_flag [9];
    bit [8:0]   m_pend;
    logic [8:0] up_v;

    logic [23:0] exp_pix;
    logic [8:0]  exp_ack;
    logic [8:0]  exp_vis;
    bit          chk_en;

    bit          lit_pix_en, lit_ack_en, lit_vis_en;
    logic [23:0] lit_pix;
    logic [8:0]  lit_ack;
    logic [8:0]  lit_vis;

    int n_vec;
    int n_miss;

    task automatic model_reset();
        for (int i = 0; i < 9; i++) begin
            m_h[i] = 0; m_dir[i] = 0; m_flag[i] = 0;
        end
        m_pend = '0;
    endtask

    function automatic logic [23:0] model_colour(input int x, input int yp);
        int y, cx, cy, c, r, i, ly;
        if (yp == 0) return 24'd0;
        y = yp - 1;
        if (x < 48 || y < 24) return BG;
        cx = x - 48; cy = y - 24;
        c = cx / 128; r = cy / 80;
        if (c > 2 || r > 2 || (cx % 128) >= 96 || (cy % 80) >= 64) return BG;
        i = r * 3 + c;
        ly = cy % 80;
        if (m_h[i] > 0 && ly >= 64 - m_h[i]) return m_flag[i] ? HITC : MOLE;
        return HOLE;
    endfunction

    task automatic model_frame();
        for (int i = 0; i < 9; i++) begin
            if (m_h[i] == 0 && m_dir[i] == 0) begin
                m_flag[i] = 0;
                if (up_v[i]) begin
                    m_h[i] = 4;
                    m_dir[i] = 1;
                end
            end else if (m_dir[i] >= 0) begin
                if (m_pend[i]) begin
                    m_dir[i] = -1; m_flag[i] = 1; exp_ack[i] = 1'b1;
                end else if (!up_v[i]) begin
                    m_dir[i] = -1;
                end else if (m_dir[i] == 1) begin
                    m_h[i] = m_h[i] + 4;
                    if (m_h[i] >= 64) begin
                        m_h[i] = 64; m_dir[i] = 0;
                    end
                end
            end else begin
                if (!m_flag[i] && up_v[i]) begin
                    m_dir[i] = 1;
                end else begin
                    m_h[i] = m_h[i] - 4;
                    if (m_h[i] <= 0) begin
                        m_h[i] = 0; m_dir[i] = 0; m_flag[i] = 0;
                    end
                end
            end
        end
        m_pend = '0;
    endtask

    // One clock: drive the request, predict the outputs after the next edge.
    task automatic step(input int x, input int yp, input logic [8:0] h);
        pixel_xpos = 11'(x);
        pixel_ypos = 11'(yp);
        hit        = h;
        mole_up    = up_v;
        exp_ack    = '0;
        if (rst) begin
            model_reset();
            exp_pix = '0;
            exp_vis = '0;
        end else begin
            exp_pix = model_colour(x, yp);
            m_pend  = m_pend | h;
            if (yp == V_DISP && x == H_DISP - 1) model_frame();
            for (int i = 0; i < 9; i++) exp_vis[i] = (m_h[i] != 0);
        end
        chk_en = 1'b1;
        @(negedge clk);
        lit_pix_en = 1'b0; lit_ack_en = 1'b0; lit_vis_en = 1'b0;
    endtask

    task automatic tick(input logic [8:0] h);
        step(H_DISP - 1, V_DISP, h);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick(9'd0);
    endtask

    task automatic want_pix(input logic [23:0] v);
        lit_pix_en = 1'b1; lit_pix = v;
    endtask

    task automatic want_ack(input logic [8:0] v);
        lit_ack_en = 1'b1; lit_ack = v;
    endtask

    task automatic want_vis(input logic [8:0] v);
        lit_vis_en = 1'b1; lit_vis = v;
    endtask

    // Reset asserted between clock edges; outputs must clear at once.
    task automatic async_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        exp_pix = '0; exp_ack = '0; exp_vis = '0;
        want_pix(24'd0); want_ack(9'd0); want_vis(9'd0);
        @(negedge clk);
        lit_pix_en = 1'b0; lit_ack_en = 1'b0; lit_vis_en = 1'b0;
    endtask

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (chk_en) begin
                n_vec++;
                if (pixel_data !== exp_pix) begin
                    n_miss++;
                    $display("FAIL pixel_data t=%0t x=%0d ypos=%0d got %h want %h",
                             $time, pixel_xpos, pixel_ypos, pixel_data, exp_pix);
                end
                n_vec++;
                if (hit_ack !== exp_ack) begin
                    n_miss++;
                    $display("FAIL hit_ack t=%0t got %b want %b", $time, hit_ack, exp_ack);
                end
                n_vec++;
                if (mole_visible !== exp_vis) begin
                    n_miss++;
                    $display("FAIL mole_visible t=%0t got %b want %b",
                             $time, mole_visible, exp_vis);
                end
                if (lit_pix_en) begin
                    n_vec++;
                    if (pixel_data !== lit_pix) begin
                        n_miss++;
                        $display("FAIL literal_pixel t=%0t got %h want %h",
                                 $time, pixel_data, lit_pix);
                    end
                end
                if (lit_ack_en) begin
                    n_vec++;
                    if (hit_ack !== lit_ack) begin
                        n_miss++;
                        $display("FAIL literal_ack t=%0t got %b want %b",
                                 $time, hit_ack, lit_ack);
                    end
                end
                if (lit_vis_en) begin
                    n_vec++;
                    if (mole_visible !== lit_vis) begin
                        n_miss++;
                        $display("FAIL literal_vis t=%0t got %b want %b",
                                 $time, mole_visible, lit_vis);
                    end
                end
                $display("vec t=%0t x=%0d ypos=%0d hit=%h up=%h -> pix=%h ack=%h vis=%h",
                         $time, pixel_xpos, pixel_ypos, hit, mole_up,
                         pixel_data, hit_ack, mole_visible);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0; n_miss = 0;
        chk_en = 1'b0;
        lit_pix_en = 1'b0; lit_ack_en = 1'b0; lit_vis_en = 1'b0;
        lit_pix = '0; lit_ack = '0; lit_vis = '0;
        exp_pix = '0; exp_ack = '0; exp_vis = '0;
        rst = 1'b1;
        pixel_xpos = '0; pixel_ypos = '0;
        h_disp = 11'(H_DISP); v_disp = 11'(V_DISP);
        up_v = '0; mole_up = '0; hit = '0;
        model_reset();
        @(negedge clk);

        // Reset state
        want_pix(24'd0); want_vis(9'd0); want_ack(9'd0);
        step(0, 1, 9'd0);
        step(0, 1, 9'd0);
        rst = 1'b0;

        // Background / hole colours and edges
        want_pix(BG);     step(0, 1, 9'd0);
        want_pix(HOLE);   step(48, 25, 9'd0);
        want_pix(HOLE);   step(143, 25, 9'd0);
        want_pix(BG);     step(144, 25, 9'd0);
        want_pix(BG);     step(47, 25, 9'd0);
        want_pix(BG);     step(48, 24, 9'd0);
        want_pix(HOLE);   step(48, 88, 9'd0);
        want_pix(BG);     step(48, 89, 9'd0);
        want_pix(24'd0);  step(48, 0, 9'd0);

        // Hit on a hidden hole is dropped
        step(60, 30, 9'h001);
        want_ack(9'd0); tick(9'd0);

        // Rise of hole 4: one step after the first tick
        up_v = 9'h010;
        tick(9'd0);
        want_pix(HOLE);   step(176, 164, 9'd0);
        want_pix(MOLE);   step(176, 165, 9'd0);
        want_pix(MOLE);   step(176, 168, 9'd0);
        want_pix(BG);     step(176, 169, 9'd0);
        want_pix(MOLE);   step(271, 168, 9'd0);
        want_pix(BG);     step(272, 168, 9'd0);
        ticks(15);
        want_vis(9'h010); want_pix(MOLE); step(176, 105, 9'd0);

        // Hit on the fully-up mole
        step(200, 120, 9'h010);
        want_ack(9'h010); tick(9'd0);
        want_ack(9'd0); want_pix(HITC); step(176, 105, 9'd0);
        up_v = 9'h000;
        tick(9'd0);
        want_pix(HOLE);   step(176, 105, 9'd0);
        want_pix(HITC);   step(176, 109, 9'd0);
        ticks(15);
        want_vis(9'd0); want_pix(HOLE); step(176, 168, 9'd0);

        // Hit while sinking after mole_up dropped is ignored
        up_v = 9'h002;
        ticks(2);
        up_v = 9'h000;
        tick(9'd0);
        step(200, 30, 9'h002);
        want_ack(9'd0); tick(9'd0);
        ticks(1);

        // Reversal on hole 2
        up_v = 9'h004;
        ticks(5);
        up_v = 9'h000;
        ticks(2);
        up_v = 9'h004;
        tick(9'd0);
        want_pix(MOLE);   step(304, 73, 9'd0);
        want_pix(HOLE);   step(304, 72, 9'd0);
        tick(9'd0);
        want_pix(MOLE);   step(304, 69, 9'd0);
        want_pix(HOLE);   step(304, 68, 9'd0);

        // Hit arriving on the tick cycle itself
        up_v = 9'h00C;
        ticks(2);
        want_ack(9'h008); tick(9'h008);
        want_pix(HITC);   step(48, 161, 9'd0);

        // Reset in the middle of an animation
        up_v = 9'h060;
        ticks(8);
        want_pix(MOLE);   step(320, 150, 9'd0);
        async_reset();
        up_v = 9'h000;
        step(320, 150, 9'd0);
        rst = 1'b0;
        want_pix(HOLE); want_vis(9'd0); step(320, 150, 9'd0);
        want_pix(HOLE);   step(60, 240, 9'd0);
        want_pix(HOLE);   step(304, 25, 9'd0);

        @(posedge clk);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
